fyp_rx_monitor: RTL and testbench
=================================

// Module: fyp_rx_monitor
// PURPOSE
//  Avalon-ST sink for the TSE MAC receive interface (eth_tse_0_receive), the receive-side counterpart of fyp_generator.
//  Accepts every frame the MAC delivers, checks framing, length and MAC error flags, and keeps saturating statistics.
//  Sits in the clk_125 domain beside fyp_generator. Its statistics outputs feed LEDs now and NIOS2 registers later.
// PARAMETERS
//  CNT_W      32    width of frame/protocol-error counters (saturating)
//  BYTE_CNT_W 48    width of good-byte counter (saturating)
//  MIN_LEN    60    min legal frame length in bytes (payload+header, CRC stripped by MAC)
//  MAX_LEN    1514  max legal frame length in bytes
//  SHIFT16    0     1 = MAC inserts 2 pad bytes at frame start; subtract 2 from length
// PORTS
//  clk              in  1     125 MHz system clock
//  reset            in  1     synchronous, active-high
//  enable           in  1     level; 1 = accept traffic
//  clear_stats      in  1     1-cycle pulse; zero all counters
//  eth_ast_rx_data  in  32    Avalon-ST data, first byte in [31:24]
//  eth_ast_rx_sop   in  1     start of packet
//  eth_ast_rx_eop   in  1     end of packet
//  eth_ast_rx_empty in  2     unused bytes on eop beat (low-order lanes)
//  eth_ast_rx_err   in  6     MAC error flags, sampled on eop beat
//  eth_ast_rx_valid in  1     beat valid
//  eth_ast_rx_rdy   out 1     sink ready (registered)
//  good_frame_cnt   out CNT_W       frames completed with no error
//  bad_frame_cnt    out CNT_W       frames completed with err/length/truncation fault
//  proto_err_cnt    out CNT_W       Avalon-ST framing violations
//  good_byte_cnt    out BYTE_CNT_W  sum of lengths of good frames
//  last_frame_len   out 16          length of most recently completed frame
//  frame_done       out 1           1-cycle pulse per completed frame
//  frame_good       out 1           qualifies frame_done; 1 = counted good
//  rx_active        out 1           1 while in IN_FRAME or DROP
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, eth_ast_rx_rdy=0, length accumulator 0.
//  Beat accepted when valid & rdy at rising clk. rdy_next = enable | (state!=IDLE): a frame in progress always drains.
//  FSM: IDLE, IN_FRAME, DROP.
//   IDLE: accept sop -> IN_FRAME, len=4 (sop&eop same beat: len=4-empty, complete immediately, stay IDLE).
//         accept !sop -> proto_err_cnt++, DROP (or stay IDLE if that beat has eop).
//   IN_FRAME: accept !sop&!eop -> len+=4. accept eop -> len+=4-empty, complete, IDLE.
//         accept sop -> proto_err_cnt++, complete old frame as bad (truncated), start new frame, len=4.
//   DROP: discard beats. Accept eop -> IDLE. Accept sop -> start new frame (IN_FRAME). No frame_done from DROP.
//  Length: 16-bit accumulator, saturates at 0xFFFF. Final len = acc - (SHIFT16?2:0), floored at 0.
//  Completion (registered, frame_done high the cycle after the eop beat is accepted):
//   good = (err==0) & MIN_LEN<=len<=MAX_LEN & not truncated.
//   good -> good_frame_cnt++, good_byte_cnt+=len; else bad_frame_cnt++. last_frame_len=len, frame_good=good.
//  All counters saturate at all-ones; they never wrap.
//  clear_stats with a completion in the same cycle: clear wins, that frame is not counted. frame_done/last_frame_len still update.
//  enable dropping mid-frame: frame finishes normally. rdy falls the cycle after completion.
//  reset mid-frame: immediate return to reset state; partial frame is not counted.
//  data content is not checked; err bits are ignored on non-eop beats.
// TESTING
//  1 enable=1, 64B frame (16 beats, empty=0, err=0) -> frame_done 1 cycle after eop, good_frame_cnt=1, good_byte_cnt=64, last_frame_len=64.
//  2 61B frame (eop beat empty=3) then 1518B frame -> good_frame_cnt=1, bad_frame_cnt=1, last_frame_len=1518, good_byte_cnt=61.
//  3 64B frame with err=6'b000010 on eop -> bad_frame_cnt=1, frame_good=0, good_byte_cnt unchanged.
//  4 sop at beat 5 of a frame, then 64B frame -> proto_err_cnt=1, bad_frame_cnt=1, good_frame_cnt=1. Stray beats with no sop -> proto_err_cnt+1, then DROP until eop.
//  5 enable->0 at beat 3 -> rdy stays 1 until eop, then 0. Counters preset near max (force) -> they saturate at all-ones.
//  6 clear_stats coincident with frame_done -> all counters 0 next cycle. reset at beat 8 -> rdy=0, counters 0, next sop starts cleanly.

Source files
------------

// File: rtl/fyp_rx_monitor.sv
// Avalon-ST receive sink for the TSE MAC: checks framing, length and MAC error
// flags per frame and keeps saturating good/bad/protocol/byte statistics.
module fyp_rx_monitor #(
    parameter int CNT_W      = 32,
    parameter int BYTE_CNT_W = 48,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int SHIFT16    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_stats,
    input  logic [31:0]           eth_ast_rx_data,
    input  logic                  eth_ast_rx_sop,
    input  logic                  eth_ast_rx_eop,
    input  logic [1:0]            eth_ast_rx_empty,
    input  logic [5:0]            eth_ast_rx_err,
    input  logic                  eth_ast_rx_valid,
    output logic                  eth_ast_rx_rdy,
    output logic [CNT_W-1:0]      good_frame_cnt,
    output logic [CNT_W-1:0]      bad_frame_cnt,
    output logic [CNT_W-1:0]      proto_err_cnt,
    output logic [BYTE_CNT_W-1:0] good_byte_cnt,
    output logic [15:0]           last_frame_len,
    output logic                  frame_done,
    output logic                  frame_good,
    output logic                  rx_active
);

    typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    localparam int          SUM_W = ((BYTE_CNT_W > 16) ? BYTE_CNT_W : 16) + 1;

    state_t                  state_reg, state_next;
    logic [15:0]             len_reg, len_next;
    logic                    rdy_reg;
    logic                    done_next, trunc_next, proto_next, good_next;
    logic [15:0]             acc_final, final_len;
    logic [2:0]              tail_bytes;
    logic [16:0]             sum_tail, sum_full;
    logic [15:0]             sat_tail, sat_full;
    logic                    accept;
    logic [SUM_W-1:0]        byte_sum;
    logic [BYTE_CNT_W-1:0]   byte_cnt_reg;
    logic [15:0]             last_len_reg;
    logic                    done_reg, good_reg;

    // Event counters: [0] good frames, [1] bad frames, [2] protocol errors
    logic [CNT_W-1:0]        cnt_reg [3];
    logic [2:0]              cnt_inc;

    assign accept     = eth_ast_rx_valid & rdy_reg;
    assign tail_bytes = 3'd4 - {1'b0, eth_ast_rx_empty};
    assign sum_tail   = {1'b0, len_reg} + {14'd0, tail_bytes};
    assign sum_full   = {1'b0, len_reg} + 17'd4;
    assign sat_tail   = sum_tail[16] ? 16'hFFFF : sum_tail[15:0];
    assign sat_full   = sum_full[16] ? 16'hFFFF : sum_full[15:0];

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        done_next  = 1'b0;
        trunc_next = 1'b0;
        proto_next = 1'b0;
        acc_final  = len_reg;
        if (accept) begin
            case (state_reg)
                IDLE, DROP: begin
                    if (eth_ast_rx_sop) begin
                        if (eth_ast_rx_eop) begin
                            done_next  = 1'b1;
                            acc_final  = {13'd0, tail_bytes};
                            state_next = IDLE;
                            len_next   = 16'd0;
                        end else begin
                            state_next = IN_FRAME;
                            len_next   = 16'd4;
                        end
                    end else if (state_reg == IDLE) begin
                        proto_next = 1'b1;
                        state_next = eth_ast_rx_eop ? IDLE : DROP;
                    end else if (eth_ast_rx_eop) begin
                        state_next = IDLE;
                    end
                end
                IN_FRAME: begin
                    if (eth_ast_rx_sop) begin
                        // Old frame is cut short; a sop+eop restart is discarded with it
                        proto_next = 1'b1;
                        done_next  = 1'b1;
                        trunc_next = 1'b1;
                        acc_final  = len_reg;
                        state_next = eth_ast_rx_eop ? IDLE : IN_FRAME;
                        len_next   = eth_ast_rx_eop ? 16'd0 : 16'd4;
                    end else if (eth_ast_rx_eop) begin
                        done_next  = 1'b1;
                        acc_final  = sat_tail;
                        state_next = IDLE;
                        len_next   = 16'd0;
                    end else begin
                        len_next   = sat_full;
                    end
                end
                default: begin
                    state_next = IDLE;
                    len_next   = 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        final_len = acc_final;
        if (SHIFT16 != 0) begin
            final_len = (acc_final >= 16'd2) ? (acc_final - 16'd2) : 16'd0;
        end
        good_next = !trunc_next && (eth_ast_rx_err == 6'd0) &&
                    (final_len >= MIN_L) && (final_len <= MAX_L);
        cnt_inc   = {proto_next, done_next & ~good_next, done_next & good_next};
        byte_sum  = SUM_W'(byte_cnt_reg) + SUM_W'(final_len);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= 16'd0;
            rdy_reg      <= 1'b0;
            done_reg     <= 1'b0;
            good_reg     <= 1'b0;
            last_len_reg <= 16'd0;
            byte_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            // A frame in progress always drains, even after enable drops
            rdy_reg   <= enable | (state_reg != IDLE);
            done_reg  <= done_next;
            good_reg  <= done_next & good_next;
            if (done_next) begin
                last_len_reg <= final_len;
            end
            if (clear_stats) begin
                byte_cnt_reg <= '0;
            end else if (done_next && good_next) begin
                if (byte_sum > SUM_W'({BYTE_CNT_W{1'b1}})) begin
                    byte_cnt_reg <= '1;
                end else begin
                    byte_cnt_reg <= byte_sum[BYTE_CNT_W-1:0];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset || clear_stats) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign eth_ast_rx_rdy = rdy_reg;
    assign good_frame_cnt = cnt_reg[0];
    assign bad_frame_cnt  = cnt_reg[1];
    assign proto_err_cnt  = cnt_reg[2];
    assign good_byte_cnt  = byte_cnt_reg;
    assign last_frame_len = last_len_reg;
    assign frame_done     = done_reg;
    assign frame_good     = good_reg;
    assign rx_active      = (state_reg != IDLE);

endmodule

// File: tb/tb_fyp_rx_monitor.sv
// Directed bench for fyp_rx_monitor; a narrow-counter second instance sees the
// same traffic to exercise saturation.
module tb_fyp_rx_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] data = '0;
    logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
    logic [1:0]  empty = '0;
    logic [5:0]  err = '0;

    logic        rdy, frame_done, frame_good, rx_active;
    logic [31:0] good_cnt, bad_cnt, proto_cnt;
    logic [47:0] byte_cnt;
    logic [15:0] last_len;

    logic        s_rdy, s_done, s_good, s_active;
    logic [2:0]  s_good_cnt, s_bad_cnt, s_proto_cnt;
    logic [7:0]  s_byte_cnt;
    logic [15:0] s_last_len;

    int tests = 0;
    int fails = 0;

    always #4 clk = ~clk;

    fyp_rx_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .eth_ast_rx_data(data), .eth_ast_rx_sop(sop), .eth_ast_rx_eop(eop),
        .eth_ast_rx_empty(empty), .eth_ast_rx_err(err), .eth_ast_rx_valid(valid),
        .eth_ast_rx_rdy(rdy), .good_frame_cnt(good_cnt), .bad_frame_cnt(bad_cnt),
        .proto_err_cnt(proto_cnt), .good_byte_cnt(byte_cnt),
        .last_frame_len(last_len), .frame_done(frame_done),
        .frame_good(frame_good), .rx_active(rx_active)
    );

    fyp_rx_monitor #(.CNT_W(3), .BYTE_CNT_W(8)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .eth_ast_rx_data(data), .eth_ast_rx_sop(sop), .eth_ast_rx_eop(eop),
        .eth_ast_rx_empty(empty), .eth_ast_rx_err(err), .eth_ast_rx_valid(valid),
        .eth_ast_rx_rdy(s_rdy), .good_frame_cnt(s_good_cnt), .bad_frame_cnt(s_bad_cnt),
        .proto_err_cnt(s_proto_cnt), .good_byte_cnt(s_byte_cnt),
        .last_frame_len(s_last_len), .frame_done(s_done),
        .frame_good(s_good), .rx_active(s_active)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic [1:0] emp, input logic [5:0] er);
        int guard = 0;
        @(negedge clk);
        sop = s; eop = e; empty = emp; err = er; valid = 1'b1; data = $urandom;
        while (!rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL rdy_timeout: rdy stayed 0 for %0d cycles", guard);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0; err = '0;
        clear_stats = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [5:0] er);
        int nb;
        logic [1:0] emp;
        nb  = (n + 3) / 4;
        emp = 2'(nb * 4 - n);
        for (int i = 0; i < nb; i++) begin
            beat(i == 0, i == nb - 1, (i == nb - 1) ? emp : 2'd0, (i == nb - 1) ? er : 6'd0);
        end
        idle_cycle();
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int rdy_drop;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_rdy", rdy, 0);
        check_eq("reset_good", good_cnt, 0);
        check_eq("reset_len", last_len, 0);
        check_eq("reset_done", frame_done, 0);
        check_eq("reset_active", rx_active, 0);
        reset = 1'b0;
        enable = 1'b1;

        // 1: plain 64-byte frame
        send_frame(64, 6'd0);
        check_eq("t1_done", frame_done, 1);
        check_eq("t1_good", frame_good, 1);
        check_eq("t1_good_cnt", good_cnt, 1);
        check_eq("t1_bytes", byte_cnt, 64);
        check_eq("t1_len", last_len, 64);
        idle_cycle();
        check_eq("t1_done_pulse", frame_done, 0);

        // 2: 61 bytes (good, minimum side) then 1518 bytes (too long)
        pulse_clear();
        send_frame(61, 6'd0);
        check_eq("t2_len61", last_len, 61);
        send_frame(1518, 6'd0);
        check_eq("t2_good_flag", frame_good, 0);
        check_eq("t2_good_cnt", good_cnt, 1);
        check_eq("t2_bad_cnt", bad_cnt, 1);
        check_eq("t2_len", last_len, 1518);
        check_eq("t2_bytes", byte_cnt, 61);

        // 3: MAC error flag on eop
        pulse_clear();
        send_frame(64, 6'b000010);
        check_eq("t3_done", frame_done, 1);
        check_eq("t3_good_flag", frame_good, 0);
        check_eq("t3_bad_cnt", bad_cnt, 1);
        check_eq("t3_bytes", byte_cnt, 0);

        // 4: sop at beat 5 truncates, then stray beats go to DROP
        pulse_clear();
        beat(1, 0, 0, 0);
        for (int i = 1; i < 5; i++) beat(0, 0, 0, 0);
        send_frame(64, 6'd0);
        check_eq("t4_proto", proto_cnt, 1);
        check_eq("t4_bad", bad_cnt, 1);
        check_eq("t4_good", good_cnt, 1);
        check_eq("t4_len", last_len, 64);
        beat(0, 0, 0, 0);
        idle_cycle();
        check_eq("t4_drop_active", rx_active, 1);
        check_eq("t4_proto2", proto_cnt, 2);
        beat(0, 0, 0, 0);
        beat(0, 1, 0, 0);
        idle_cycle();
        check_eq("t4_drop_nodone", frame_done, 0);
        check_eq("t4_drop_idle", rx_active, 0);
        check_eq("t4_drop_bad", bad_cnt, 1);
        check_eq("t4_proto_final", proto_cnt, 2);

        // 5: enable drops at beat 3; frame drains, then rdy falls
        rdy_drop = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) enable = 1'b0;
            beat(i == 0, i == 15, 0, 0);
            if (!rdy) rdy_drop++;
        end
        idle_cycle();
        check_eq("t5_rdy_held", rdy_drop, 0);
        check_eq("t5_done", frame_done, 1);
        check_eq("t5_good_cnt", good_cnt, 2);
        idle_cycle();
        check_eq("t5_rdy_low", rdy, 0);
        enable = 1'b1;

        // 5b: saturation, observed on the narrow-counter instance
        pulse_reset();
        for (int i = 0; i < 9; i++) send_frame(64, 6'd0);
        for (int i = 0; i < 9; i++) send_frame(64, 6'b000001);
        check_eq("t5_sat_good", s_good_cnt, 7);
        check_eq("t5_sat_bad", s_bad_cnt, 7);
        check_eq("t5_sat_bytes", s_byte_cnt, 255);
        check_eq("t5_wide_good", good_cnt, 9);
        check_eq("t5_wide_bytes", byte_cnt, 576);

        // 6: clear_stats coincident with completion of a 68-byte frame
        for (int i = 0; i < 17; i++) beat(i == 0, i == 16, 0, 0);
        clear_stats = 1'b1;
        idle_cycle();
        check_eq("t6_clr_done", frame_done, 1);
        check_eq("t6_clr_len", last_len, 68);
        check_eq("t6_clr_good", good_cnt, 0);
        check_eq("t6_clr_bad", bad_cnt, 0);
        check_eq("t6_clr_bytes", byte_cnt, 0);

        // 6b: reset at beat 8 of a frame
        send_frame(100, 6'd0);
        check_eq("t6_pre_good", good_cnt, 1);
        for (int i = 0; i < 8; i++) beat(i == 0, 0, 0, 0);
        pulse_reset();
        check_eq("t6_rst_rdy", rdy, 0);
        check_eq("t6_rst_good", good_cnt, 0);
        check_eq("t6_rst_active", rx_active, 0);
        check_eq("t6_rst_len", last_len, 0);
        send_frame(64, 6'd0);
        check_eq("t6_after_good", good_cnt, 1);
        check_eq("t6_after_bytes", byte_cnt, 64);
        check_eq("t6_after_proto", proto_cnt, 0);
        check_eq("t6_after_bad", bad_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
